// File: rtl/regfile_2r1w_init.sv
// Two-read, one-write register file with a hardware zeroing sequencer.
// Reads are combinational; the array has no reset so it maps to distributed RAM.
module regfile_2r1w_init #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_in_run;
    logic              w_wr_live;
    logic              w_wr_accept;
    logic              w_wr_drop_nxt;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rs_mem, w_rt_mem;

    assign w_in_run      = (r_state == RUN);
    // A live write lands on this edge; it is also what the bypass forwards.
    assign w_wr_live     = w_in_run && wr_en && !clr;
    assign w_wr_accept   = w_wr_live && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_wr_drop_nxt = wr_en && (!w_in_run || clr);

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            INIT: begin
                if (clr) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_ptr + PTR_ONE;
                    if (r_ptr == PTR_LAST) w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    w_state_nxt = INIT;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state   <= INIT;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_drop <= w_wr_drop_nxt;
        end
    end

    // Single write port shared by the zeroing sequencer and the datapath.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = wr_addr;
        w_mem_wdata = wr_data;
        if (!w_in_run) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = '0;
        end else if (w_wr_accept) begin
            w_mem_we = 1'b1;
        end
    end

    // NOTE: the array is deliberately not reset; the sequencer zeroes it and reads are masked until RUN.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    assign w_rs_mem = r_mem[rs_addr];
    assign w_rt_mem = r_mem[rt_addr];

    function automatic logic [DATA_W-1:0] sel_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] mem_val,
        input logic              in_run,
        input logic              wr_live,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (!in_run)                               return '0;
        if ((ZERO_REG != 0) && (addr == '0))       return '0;
        if ((BYPASS != 0) && wr_live && (waddr == addr)) return wdata;
        return mem_val;
    endfunction

    assign rs_data = sel_read(rs_addr, w_rs_mem, w_in_run, w_wr_live, wr_addr, wr_data);
    assign rt_data = sel_read(rt_addr, w_rt_mem, w_in_run, w_wr_live, wr_addr, wr_data);
    assign busy    = !w_in_run;
    assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_2r1w_init.sv
// Self-checking bench for regfile_2r1w_init: vector table with a scoreboard queue,
// plus hand-written sequences for reset, clear, drops and async reset.
module tb_regfile_2r1w_init;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic [31:0] wr_data;
    logic        wr_en, clr;
    logic [31:0] rs_data, rt_data, nb_rs_data, nb_rt_data;
    logic        busy, wr_drop, nb_busy, nb_wr_drop;

    int checks   = 0;
    int failures = 0;

    regfile_2r1w_init u_dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr(clr), .busy(busy), .wr_drop(wr_drop)
    );

    regfile_2r1w_init #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(nb_rs_data), .rt_data(nb_rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr(clr), .busy(nb_busy), .wr_drop(nb_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_rs_nb;
        logic [31:0] exp_rt_nb;
    } vec_t;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] rs_nb;
        logic [31:0] rt_nb;
    } exp_t;

    vec_t vecs[9];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr     = 1'b0;
    endtask

    // Counts edges until busy falls, bounded so a stuck sequencer still ends the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            check({tag, "_rs"}, rs_data, 32'h0);
            check({tag, "_rt"}, rt_data, 32'h0);
        end
    endtask

    initial begin
        int   n;
        exp_t e;

        vecs[0] = '{1'b1, 5'd7,  32'h0000_00A5, 5'd7, 5'd31, 32'h0000_00A5, 32'h0,         32'h0,         32'h0};
        vecs[1] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd7, 5'd31, 32'h0000_00A5, 32'hDEAD_BEEF, 32'h0000_00A5, 32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd7, 5'd31, 32'h0000_00A5, 32'hDEAD_BEEF, 32'h0000_00A5, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 5'd0,  32'h0000_1234, 5'd0, 5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd0, 5'd7,  32'h0,         32'h0000_00A5, 32'h0,         32'h0000_00A5};
        vecs[5] = '{1'b1, 5'd5,  32'h0000_0055, 5'd5, 5'd5,  32'h0000_0055, 32'h0000_0055, 32'h0,         32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd5, 5'd7,  32'h0000_0055, 32'h0000_00A5, 32'h0000_0055, 32'h0000_00A5};
        vecs[7] = '{1'b1, 5'd7,  32'h0000_1111, 5'd7, 5'd5,  32'h0000_1111, 32'h0000_0055, 32'h0000_00A5, 32'h0000_0055};
        vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd7, 5'd7,  32'h0000_1111, 32'h0000_1111, 32'h0000_1111, 32'h0000_1111};

        // Reset release
        rst_n = 1'b0;
        idle();
        rs_addr = 5'd7;
        rt_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 32'h1);
        check("reset_drop", wr_drop, 32'h0);
        check("reset_rs", rs_data, 32'h0);
        rst_n = 1'b1;
        wait_idle(n);
        check("init_len", n, 32'd32);
        check_all_zero("post_reset");

        // Vector table, each row scored through the queue
        for (int i = 0; i < 9; i++) begin
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            rs_addr = vecs[i].ra;
            rt_addr = vecs[i].rb;
            exp_q.push_back('{vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_rs_nb, vecs[i].exp_rt_nb});
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d_rs", i), rs_data, e.rs);
            check($sformatf("vec%0d_rt", i), rt_data, e.rt);
            check($sformatf("vec%0d_rs_nb", i), nb_rs_data, e.rs_nb);
            check($sformatf("vec%0d_rt_nb", i), nb_rt_data, e.rt_nb);
            check($sformatf("vec%0d_drop", i), wr_drop, 32'h0);
            tick();
        end
        idle();

        // Clear colliding with a write
        for (int a = 1; a < 32; a++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(a);
            wr_data = 32'hC0DE_0000 | 32'(a);
            tick();
        end
        idle();
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h0000_0077;
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        #1;
        check("clr_nobypass_rs", rs_data, 32'hC0DE_0003);
        tick();
        idle();
        check("clr_busy", busy, 32'h1);
        check("clr_drop", wr_drop, 32'h1);
        check("clr_init_rs", rs_data, 32'h0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == 1) check("clr_drop_end", wr_drop, 32'h0);
        end
        check("clr_len", n, 32'd32);
        check_all_zero("post_clr");

        // Writes during INIT, then a clear mid-INIT restarts the sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        for (int k = 0; k < 4; k++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(k + 1);
            wr_data = 32'h0000_BAD0 + 32'(k);
            rs_addr = 5'(k + 1);
            #1;
            check($sformatf("init_wr%0d_rs", k), rs_data, 32'h0);
            tick();
            check($sformatf("init_wr%0d_drop", k), wr_drop, 32'h1);
        end
        idle();
        tick();
        check("init_drop_end", wr_drop, 32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("init_clr_drop", wr_drop, 32'h0);
        wait_idle(n);
        check("init_clr_len", n, 32'd32);
        check_all_zero("post_init_wr");

        // Async reset mid-RUN
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h0000_0099;
        tick();
        idle();
        rs_addr = 5'd9;
        #1;
        check("pre_rst_rs", rs_data, 32'h0000_0099);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 32'h1);
        check("async_rs", rs_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle(n);
        check("async_len", n, 32'd32);
        check_all_zero("post_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
